exec_cond_unit: RTL and testbench

- Execute-stage consumer of the ALU's condition-code output in the pipelined Y86 core.
- Owns the architectural CC register and evaluates jXX/cmovXX conditions against it.
- Squashes the cmov destination when the condition fails and flags jump mispredicts (the core predicts every jump taken).
- Registers the E-to-M pipeline fields with stall/bubble control.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/cc_reg.sv | 22 ++
 rtl/exec_cond_unit.sv | 102 ++++++++++
 tb/tb_exec_cond_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared constants for the Y86 pipeline: icodes, register IDs,
// condition selectors and condition-code layout.
package y86_pkg;

    // Instruction codes seen by the execute stage
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;

    // Register ID meaning "no destination"
    localparam logic [3:0] RNONE = 4'hF;

    // ifun encodings used as condition selectors by jXX/cmovXX
    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    // Bit positions inside the {ZF,SF,OF} condition-code vector
    localparam int ZF = 2;
    localparam int SF = 1;
    localparam int OF = 0;

    // CC value after reset: zero flag set, others clear
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cc_reg.sv
// Small register with synchronous reset and load enable,
// used to hold the architectural condition codes.
module cc_reg #(
    parameter logic [2:0] RST_VAL = 3'b100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] d,
    output logic [2:0] q
);

    // Reset wins over load; otherwise hold unless load is asserted
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exec_cond_unit.sv
// Execute-stage condition handling: owns the CC register, evaluates
// jXX/cmovXX conditions, squashes failed cmov destinations, flags
// jump mispredicts and registers the E-to-M pipeline fields.
module exec_cond_unit
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [3:0]       E_dstE,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [2:0]       new_cc,
    input  logic             m_exc,
    input  logic             W_exc,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic [2:0]       cc,
    output logic             e_Cnd,
    output logic [3:0]       e_dstE,
    output logic             e_mispredict,
    output logic [3:0]       M_icode,
    output logic             M_Cnd,
    output logic [3:0]       M_dstE,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic             M_mispredict
);

    logic set_cc;
    logic zf;
    logic sf;
    logic of;

    // Only OPq writes CC, and never while a later stage holds an exception
    assign set_cc = (E_icode == I_OPQ) & ~m_exc & ~W_exc;

    cc_reg #(
        .RST_VAL(CC_RESET)
    ) u_cc_reg (
        .clock(clock),
        .reset(reset),
        .load (set_cc),
        .d    (new_cc),
        .q    (cc)
    );

    assign zf = cc[ZF];
    assign sf = cc[SF];
    assign of = cc[OF];

    // Evaluate the selected condition against the current (pre-update) CC
    always_comb begin
        e_Cnd = 1'b0;
        unique case (E_ifun)
            C_ALWAYS: e_Cnd = 1'b1;
            C_LE:     e_Cnd = (sf ^ of) | zf;
            C_L:      e_Cnd = sf ^ of;
            C_E:      e_Cnd = zf;
            C_NE:     e_Cnd = ~zf;
            C_GE:     e_Cnd = ~(sf ^ of);
            C_G:      e_Cnd = ~(sf ^ of) & ~zf;
            default:  e_Cnd = 1'b0;
        endcase
    end

    // A cmov whose condition fails must not write its destination;
    // the core predicts every jump taken, so a false jXX is a mispredict
    always_comb begin
        e_dstE       = E_dstE;
        e_mispredict = 1'b0;
        if ((E_icode == I_CMOV) && !e_Cnd) begin
            e_dstE = RNONE;
        end
        if ((E_icode == I_JXX) && !e_Cnd) begin
            e_mispredict = 1'b1;
        end
    end

    // E-to-M pipeline register: reset > bubble > stall > load
    always_ff @(posedge clock) begin
        if (reset || M_bubble) begin
            M_icode      <= I_NOP;
            M_Cnd        <= 1'b0;
            M_dstE       <= RNONE;
            M_valE       <= '0;
            M_valA       <= '0;
            M_mispredict <= 1'b0;
        end else if (!M_stall) begin
            M_icode      <= E_icode;
            M_Cnd        <= e_Cnd;
            M_dstE       <= e_dstE;
            M_valE       <= e_valE;
            M_valA       <= E_valA;
            M_mispredict <= e_mispredict;
        end
    end

endmodule

// File: tb/tb_exec_cond_unit.sv
// Directed bench for exec_cond_unit with a queue-based scoreboard of
// expected post-edge state, plus explicit constant checks.
module tb_exec_cond_unit;

    logic        clock;
    logic        reset;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [3:0]  E_dstE;
    logic [63:0] E_valA;
    logic [63:0] e_valE;
    logic [2:0]  new_cc;
    logic        m_exc;
    logic        W_exc;
    logic        M_stall;
    logic        M_bubble;
    logic [2:0]  cc;
    logic        e_Cnd;
    logic [3:0]  e_dstE;
    logic        e_mispredict;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [3:0]  M_dstE;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic        M_mispredict;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  cc;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  dste;
        logic [63:0] vale;
        logic [63:0] vala;
        logic        mis;
    } snap_t;

    snap_t sb_q[$];
    snap_t cur;

    exec_cond_unit #(.WIDTH(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .E_icode     (E_icode),
        .E_ifun      (E_ifun),
        .E_dstE      (E_dstE),
        .E_valA      (E_valA),
        .e_valE      (e_valE),
        .new_cc      (new_cc),
        .m_exc       (m_exc),
        .W_exc       (W_exc),
        .M_stall     (M_stall),
        .M_bubble    (M_bubble),
        .cc          (cc),
        .e_Cnd       (e_Cnd),
        .e_dstE      (e_dstE),
        .e_mispredict(e_mispredict),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_dstE      (M_dstE),
        .M_valE      (M_valE),
        .M_valA      (M_valA),
        .M_mispredict(M_mispredict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference condition table written from the ISA definition
    function automatic logic model_cond(input logic [3:0] f, input logic [2:0] c);
        logic z, s, o;
        z = c[2];
        s = c[1];
        o = c[0];
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return (s != o) || z;
            4'd2:    return s != o;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return s == o;
            4'd6:    return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Check combinational outputs, push predicted post-edge state, clock, compare
    task automatic tick(input string tag);
        logic  cnd;
        logic  mis;
        logic [3:0] dst;
        snap_t nx;
        snap_t got;
        #1;
        cnd = model_cond(E_ifun, cur.cc);
        dst = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
        mis = (E_icode == 4'h7) && !cnd;
        chk({tag, ".cc_pre"}, {61'd0, cc}, {61'd0, cur.cc});
        chk({tag, ".e_Cnd"}, {63'd0, e_Cnd}, {63'd0, cnd});
        chk({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, dst});
        chk({tag, ".e_mis"}, {63'd0, e_mispredict}, {63'd0, mis});
        nx = cur;
        if (reset) begin
            nx = '{cc: 3'b100, icode: 4'h1, cnd: 1'b0, dste: 4'hF, vale: 64'd0, vala: 64'd0, mis: 1'b0};
        end else begin
            if (E_icode == 4'h6 && !m_exc && !W_exc) nx.cc = new_cc;
            if (M_bubble) begin
                nx.icode = 4'h1; nx.cnd = 1'b0; nx.dste = 4'hF;
                nx.vale = 64'd0; nx.vala = 64'd0; nx.mis = 1'b0;
            end else if (!M_stall) begin
                nx.icode = E_icode; nx.cnd = cnd; nx.dste = dst;
                nx.vale = e_valE; nx.vala = E_valA; nx.mis = mis;
            end
        end
        sb_q.push_back(nx);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, got.cc});
        chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, got.icode});
        chk({tag, ".M_Cnd"}, {63'd0, M_Cnd}, {63'd0, got.cnd});
        chk({tag, ".M_dstE"}, {60'd0, M_dstE}, {60'd0, got.dste});
        chk({tag, ".M_valE"}, M_valE, got.vale);
        chk({tag, ".M_valA"}, M_valA, got.vala);
        chk({tag, ".M_mis"}, {63'd0, M_mispredict}, {63'd0, got.mis});
        cur = got;
    endtask

    initial begin
        reset = 1'b1; E_icode = 4'h1; E_ifun = 4'h0; E_dstE = 4'hF;
        E_valA = 64'd0; e_valE = 64'd0; new_cc = 3'b000;
        m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;

        // Reset held for two cycles
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst.cc", {61'd0, cc}, 64'h4);
        chk("rst.M_icode", {60'd0, M_icode}, 64'h1);
        chk("rst.M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst.M_Cnd", {63'd0, M_Cnd}, 64'h0);
        chk("rst.M_mis", {63'd0, M_mispredict}, 64'h0);
        chk("rst.M_valE", M_valE, 64'h0);
        cur = '{cc: 3'b100, icode: 4'h1, cnd: 1'b0, dste: 4'hF, vale: 64'd0, vala: 64'd0, mis: 1'b0};

        // OPq sets cc=010
        reset = 1'b0; E_icode = 4'h6; E_ifun = 4'h0; new_cc = 3'b010;
        E_dstE = 4'h2; e_valE = 64'h55; E_valA = 64'h11;
        tick("opq1");
        chk("opq1.cc_now", {61'd0, cc}, 64'h2);

        // jl taken against cc=010
        E_icode = 4'h7; E_ifun = 4'h2; E_dstE = 4'hF; E_valA = 64'h40;
        #1;
        chk("jl.e_Cnd", {63'd0, e_Cnd}, 64'h1);
        chk("jl.e_mis", {63'd0, e_mispredict}, 64'h0);
        tick("jl");

        // je not taken -> mispredict
        E_ifun = 4'h3; E_valA = 64'h48;
        #1;
        chk("je.e_Cnd", {63'd0, e_Cnd}, 64'h0);
        chk("je.e_mis", {63'd0, e_mispredict}, 64'h1);
        tick("je");
        chk("je.M_mis", {63'd0, M_mispredict}, 64'h1);

        // cc=000, cmovle fails and squashes dstE
        E_icode = 4'h6; new_cc = 3'b000;
        tick("opq000");
        E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h3; e_valE = 64'h99;
        #1;
        chk("cmovle0.e_Cnd", {63'd0, e_Cnd}, 64'h0);
        chk("cmovle0.e_dstE", {60'd0, e_dstE}, 64'hF);
        tick("cmovle0");
        chk("cmovle0.M_dstE", {60'd0, M_dstE}, 64'hF);

        // cc=100, cmovle passes
        E_icode = 4'h6; new_cc = 3'b100;
        tick("opq100");
        E_icode = 4'h2; E_ifun = 4'h1; E_dstE = 4'h3;
        #1;
        chk("cmovle1.e_dstE", {60'd0, e_dstE}, 64'h3);
        tick("cmovle1");
        chk("cmovle1.M_dstE", {60'd0, M_dstE}, 64'h3);

        // Exceptions block the CC write
        E_icode = 4'h6; E_ifun = 4'h0; new_cc = 3'b011; m_exc = 1'b1;
        tick("mexc");
        chk("mexc.cc_now", {61'd0, cc}, 64'h4);
        m_exc = 1'b0; W_exc = 1'b1;
        tick("wexc");
        chk("wexc.cc_now", {61'd0, cc}, 64'h4);
        W_exc = 1'b0;
        tick("noexc");
        chk("noexc.cc_now", {61'd0, cc}, 64'h3);

        // Stall holds, bubble beats stall
        E_icode = 4'h1; E_valA = 64'h1234; M_stall = 1'b1;
        tick("stall");
        chk("stall.M_valA", M_valA, 64'h48);
        M_bubble = 1'b1;
        tick("stallbub");
        chk("stallbub.M_icode", {60'd0, M_icode}, 64'h1);
        chk("stallbub.M_dstE", {60'd0, M_dstE}, 64'hF);
        M_stall = 1'b0; M_bubble = 1'b0;

        // Mixed traffic across all condition selectors
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: E_icode = 4'h2;
                1: E_icode = 4'h6;
                2: E_icode = 4'h7;
                default: E_icode = 4'h0;
            endcase
            E_ifun = 4'($urandom_range(0, 8));
            E_dstE = 4'($urandom_range(0, 14));
            E_valA = {$urandom, $urandom};
            e_valE = {$urandom, $urandom};
            new_cc = 3'($urandom_range(0, 7));
            m_exc = ($urandom_range(0, 5) == 0);
            W_exc = ($urandom_range(0, 5) == 0);
            M_stall = ($urandom_range(0, 5) == 0);
            M_bubble = ($urandom_range(0, 7) == 0);
            tick("mix");
        end
        m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;

        // Reset concurrent with an OPq and valid E fields
        reset = 1'b1; E_icode = 4'h6; new_cc = 3'b001; E_dstE = 4'h5;
        E_valA = 64'hABCD; e_valE = 64'h77;
        tick("rstopq");
        chk("rstopq.cc_now", {61'd0, cc}, 64'h4);
        chk("rstopq.M_icode", {60'd0, M_icode}, 64'h1);
        chk("rstopq.M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rstopq.M_valA", M_valA, 64'h0);
        chk("sb.empty", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
